red_pitaya_limiter: RTL and testbench
=====================================

// Module: red_pitaya_limiter
// PURPOSE
//  Two-channel programmable output clamp between the lockbox controllers and the DACs.
//  Each channel clamps a signed 14-bit sample to a bus-programmed [min,max] window.
//  Each channel also flags on which rail it is saturated.
//  Limits are read/written over the standard Red Pitaya sys bus.
// PARAMETERS
//  none (data width fixed at 14 bits, two's complement; bus width fixed at 32 bits)
// PORTS
//  clk_i           in   1   system clock (125 MHz ADC clock)
//  rstn_i          in   1   reset, synchronous, active-low
//  dat_a_i         in   14  channel A input sample, signed
//  dat_a_o         out  14  channel A clamped output, signed
//  dat_a_railed_o  out  2   channel A rail flags: [1]=at upper limit, [0]=at lower limit
//  dat_b_i         in   14  channel B input sample, signed
//  dat_b_o         out  14  channel B clamped output, signed
//  dat_b_railed_o  out  2   channel B rail flags, same encoding as A
//  sys_addr        in   32  bus address (byte address; decode bits [19:0])
//  sys_wdata       in   32  bus write data
//  sys_wen         in   1   bus write strobe, one cycle
//  sys_ren         in   1   bus read strobe, one cycle
//  sys_rdata       out  32  bus read data
//  sys_err         out  1   bus error, tied 0
//  sys_ack         out  1   bus acknowledge
// BEHAVIOUR
//  Register map (14-bit signed values, written from sys_wdata[13:0]):
//   0x00 A min, 0x04 A max, 0x08 B min, 0x0C B max
//  - Reset values: min = -8192 (14'h2000), max = +8191 (14'h1FFF), giving full-range pass-through.
//  - Writes: on a sys_wen cycle with a matching address, the register updates at the same clock edge.
//    Writes to unmapped addresses are ignored.
//  - Reads: sys_rdata = sign-extended 14-bit register value, registered.
//    Unmapped addresses read 0.
//  - sys_ack: registered, asserted exactly one cycle after any sys_wen or sys_ren, mapped or not.
//    sys_err is always 0.
//  - Clamp, per channel, registered (latency 1 clk), all comparisons signed:
//     if in > max      : out = max, railed = 2'b10
//     else if in < min : out = min, railed = 2'b01
//     else             : out = in,  railed = 2'b00
//  - An input equal to a limit passes unchanged and is not flagged.
//  - If min > max, the upper check has priority: out = max, railed = 2'b10 whenever in > max.
//  - Limit changes take effect on the next sample.
//    A write that puts the current input outside the window clamps the output 1 clk after the write edge.
//  - On reset: dat_x_o = 0, dat_x_railed_o = 2'b00, sys_ack = 0, sys_rdata = 0, limits = reset values.
//    Reset asserted mid-operation restores all of these on the next edge.
//  - Channels are fully independent; identical logic per channel.
// TESTING
//  - Reset, then in = 5000, no writes -> out = 5000, railed = 00.
//    Reading 0x00 returns 32'hFFFFE000; reading 0x04 returns 32'h00001FFF.
//  - Write A min = -1000, A max = 1000; in = 2000 -> out = 1000, railed = 10.
//  - Same limits, in = -2000 -> out = -1000, railed = 01.
//  - Same limits, in = 500 -> out = 500, railed = 00.
//    in = 1000 (equal to max) -> out = 1000, railed = 00.
//  - in = 500, write A max = 0 -> within 2 clk: out = 0, railed = 10.
//    Channel B is unaffected throughout.
//  - Bus: every wen/ren gives a one-cycle ack one clk later, with err = 0.
//    Write to 0x40 is ignored; read from 0x40 returns 0.

Source files
------------

// File: rtl/red_pitaya_limiter_if.sv
// Red Pitaya sys bus: byte-addressed single-cycle read/write strobes with registered ack.
interface red_pitaya_limiter_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );
endinterface

// File: rtl/red_pitaya_limiter.sv
// Two-channel signed 14-bit clamp to bus-programmed [min,max] windows, with rail flags.
// Latency: 1 clk for samples; bus ack and read data 1 clk after the strobe.
// Backpressure: none; samples stream every cycle, bus always acks on the next cycle.
module red_pitaya_limiter (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [13:0]          dat_a_i,
    output logic [13:0]          dat_a_o,
    output logic [1:0]           dat_a_railed_o,
    input  logic [13:0]          dat_b_i,
    output logic [13:0]          dat_b_o,
    output logic [1:0]           dat_b_railed_o,
    red_pitaya_limiter_if.slave  bus
);
    localparam logic [13:0] MIN_RST = 14'h2000;
    localparam logic [13:0] MAX_RST = 14'h1FFF;

    logic signed [13:0] a_min, a_max, b_min, b_max;
    logic [19:0]        addr;
    logic               unused_bits;

    assign addr        = bus.sys_addr[19:0];
    assign unused_bits = ^{bus.sys_addr[31:20], bus.sys_wdata[31:14]};
    assign bus.sys_err = 1'b0;

    // Upper rail is checked first so an inverted window (min > max) still resolves deterministically.
    function automatic logic [15:0] clamp(input logic signed [13:0] x,
                                          input logic signed [13:0] mn,
                                          input logic signed [13:0] mx);
        logic [15:0] r;
        if (x > mx)
            r = {2'b10, mx};
        else if (x < mn)
            r = {2'b01, mn};
        else
            r = {2'b00, x};
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_min <= MIN_RST;
            a_max <= MAX_RST;
            b_min <= MIN_RST;
            b_max <= MAX_RST;
        end else if (bus.sys_wen) begin
            case (addr)
                20'h00000: a_min <= bus.sys_wdata[13:0];
                20'h00004: a_max <= bus.sys_wdata[13:0];
                20'h00008: b_min <= bus.sys_wdata[13:0];
                20'h0000C: b_max <= bus.sys_wdata[13:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bus.sys_ack   <= 1'b0;
            bus.sys_rdata <= 32'h0;
        end else begin
            bus.sys_ack <= bus.sys_wen | bus.sys_ren;
            if (bus.sys_ren) begin
                case (addr)
                    20'h00000: bus.sys_rdata <= {{18{a_min[13]}}, a_min};
                    20'h00004: bus.sys_rdata <= {{18{a_max[13]}}, a_max};
                    20'h00008: bus.sys_rdata <= {{18{b_min[13]}}, b_min};
                    20'h0000C: bus.sys_rdata <= {{18{b_max[13]}}, b_max};
                    default:   bus.sys_rdata <= 32'h0;
                endcase
            end
        end
    end

    // Clamp uses the registered limits, so a write is visible on the sample after its edge.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            dat_a_o        <= 14'h0;
            dat_a_railed_o <= 2'b00;
            dat_b_o        <= 14'h0;
            dat_b_railed_o <= 2'b00;
        end else begin
            {dat_a_railed_o, dat_a_o} <= clamp($signed(dat_a_i), a_min, a_max);
            {dat_b_railed_o, dat_b_o} <= clamp($signed(dat_b_i), b_min, b_max);
        end
    end
endmodule

// File: tb/tb_red_pitaya_limiter.sv
// Directed self-checking bench for red_pitaya_limiter: clamp, rail flags, register map, ack, reset.
module tb_red_pitaya_limiter;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [13:0] dat_a_i, dat_b_i;
    logic [13:0] dat_a_o, dat_b_o;
    logic [1:0]  dat_a_railed_o, dat_b_railed_o;
    int          checks = 0;
    int          failures = 0;

    red_pitaya_limiter_if bus ();

    red_pitaya_limiter dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .dat_a_i        (dat_a_i),
        .dat_a_o        (dat_a_o),
        .dat_a_railed_o (dat_a_railed_o),
        .dat_b_i        (dat_b_i),
        .dat_b_o        (dat_b_o),
        .dat_b_railed_o (dat_b_railed_o),
        .bus            (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [13:0] d, input logic [1:0] r);
        chk({tag, "_a_dat"}, {18'h0, dat_a_o}, {18'h0, d});
        chk({tag, "_a_rail"}, {30'h0, dat_a_railed_o}, {30'h0, r});
    endtask

    task automatic chk_b(input string tag, input logic [13:0] d, input logic [1:0] r);
        chk({tag, "_b_dat"}, {18'h0, dat_b_o}, {18'h0, d});
        chk({tag, "_b_rail"}, {30'h0, dat_b_railed_o}, {30'h0, r});
    endtask

    task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bus.sys_addr  = addr;
        bus.sys_wdata = data;
        bus.sys_wen   = 1'b1;
        tick();
        bus.sys_wen = 1'b0;
        chk({tag, "_wack"}, {31'h0, bus.sys_ack}, 32'h1);
        chk({tag, "_werr"}, {31'h0, bus.sys_err}, 32'h0);
        tick();
        chk({tag, "_wack_drop"}, {31'h0, bus.sys_ack}, 32'h0);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.sys_addr = addr;
        bus.sys_ren  = 1'b1;
        tick();
        bus.sys_ren = 1'b0;
        chk({tag, "_rack"}, {31'h0, bus.sys_ack}, 32'h1);
        chk({tag, "_rerr"}, {31'h0, bus.sys_err}, 32'h0);
        chk({tag, "_rdata"}, bus.sys_rdata, exp);
        tick();
        chk({tag, "_rack_drop"}, {31'h0, bus.sys_ack}, 32'h0);
    endtask

    initial begin
        rstn_i        = 1'b0;
        dat_a_i       = 14'h0;
        dat_b_i       = 14'h0;
        bus.sys_addr  = 32'h0;
        bus.sys_wdata = 32'h0;
        bus.sys_wen   = 1'b0;
        bus.sys_ren   = 1'b0;
        tick();
        tick();
        chk_a("reset", 14'h0, 2'b00);
        chk_b("reset", 14'h0, 2'b00);
        chk("reset_ack", {31'h0, bus.sys_ack}, 32'h0);
        chk("reset_rdata", bus.sys_rdata, 32'h0);
        rstn_i = 1'b1;

        // Full-range pass-through at reset limits
        dat_a_i = 14'sd5000;
        dat_b_i = -14'sd3000;
        tick();
        chk_a("pass5000", 14'sd5000, 2'b00);
        chk_b("pass_b", -14'sd3000, 2'b00);
        bus_read("rd_amin_rst", 32'h00, 32'hFFFFE000);
        bus_read("rd_amax_rst", 32'h04, 32'h00001FFF);

        bus_write("wr_amin", 32'h00, 32'hFFFFFC18);
        bus_write("wr_amax", 32'h04, 32'd1000);
        dat_a_i = 14'sd2000;
        tick();
        chk_a("above_max", 14'sd1000, 2'b10);
        dat_a_i = -14'sd2000;
        tick();
        chk_a("below_min", -14'sd1000, 2'b01);
        dat_a_i = 14'sd500;
        tick();
        chk_a("inside", 14'sd500, 2'b00);
        dat_a_i = 14'sd1000;
        tick();
        chk_a("eq_max", 14'sd1000, 2'b00);
        dat_a_i = -14'sd1000;
        tick();
        chk_a("eq_min", -14'sd1000, 2'b00);

        // Limit write clamps the held input one clock after the write edge
        dat_a_i = 14'sd500;
        tick();
        chk_a("pre_shrink", 14'sd500, 2'b00);
        bus_write("wr_amax0", 32'h04, 32'h0);
        chk_a("post_shrink", 14'h0, 2'b10);
        chk_b("b_untouched", -14'sd3000, 2'b00);
        bus_read("rd_amax0", 32'h04, 32'h0);
        bus_read("rd_amin", 32'h00, 32'hFFFFFC18);

        // Unmapped address
        bus_write("wr_unmapped", 32'h40, 32'd123);
        bus_read("rd_unmapped", 32'h40, 32'h0);
        bus_read("rd_amin_after_unmapped", 32'h00, 32'hFFFFFC18);
        bus_read("rd_bmax_rst", 32'h0C, 32'h00001FFF);

        // Channel B, including an inverted window
        bus_write("wr_bmax", 32'h0C, 32'd100);
        tick();
        chk_b("b_below_newmax", -14'sd3000, 2'b00);
        dat_b_i = 14'sd200;
        tick();
        chk_b("b_above_max", 14'sd100, 2'b10);
        chk_a("a_indep", 14'h0, 2'b10);
        bus_write("wr_bmin", 32'h08, 32'd500);
        bus_read("rd_bmin", 32'h08, 32'd500);
        dat_b_i = 14'sd300;
        tick();
        chk_b("inv_upper_prio", 14'sd100, 2'b10);
        dat_b_i = 14'sd50;
        tick();
        chk_b("inv_lower", 14'sd500, 2'b01);

        // Mid-operation reset restores outputs and limits
        bus.sys_addr = 32'h04;
        bus.sys_ren  = 1'b1;
        tick();
        bus.sys_ren = 1'b0;
        rstn_i      = 1'b0;
        dat_a_i     = 14'sd5000;
        tick();
        chk_a("midrst", 14'h0, 2'b00);
        chk_b("midrst", 14'h0, 2'b00);
        chk("midrst_ack", {31'h0, bus.sys_ack}, 32'h0);
        chk("midrst_rdata", bus.sys_rdata, 32'h0);
        rstn_i = 1'b1;
        tick();
        chk_a("after_rst", 14'sd5000, 2'b00);
        bus_read("rd_bmin_after_rst", 32'h08, 32'hFFFFE000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
